// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse-init constants, state encodings and the init-sequence command ROM.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] MOUSE_ID   = 8'h00;

    localparam int NUM_STEPS = 6;

    typedef enum logic [2:0] {
        ST_START, ST_NEXT, ST_TX, ST_RX, ST_CHECK, ST_DONE, ST_FAIL, ST_ERROR
    } init_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_INHIBIT, TX_RTS, TX_SHIFT, TX_ACK, TX_WAIT_HI
    } tx_state_t;

    function automatic logic step_is_tx(input logic [2:0] step);
        return (step == 3'd0) || (step == 3'd4);
    endfunction

    // Byte sent on TX steps, byte expected on RX steps.
    function automatic logic [7:0] step_byte(input logic [2:0] step);
        case (step)
            3'd0:    return CMD_RESET;
            3'd1:    return RSP_ACK;
            3'd2:    return RSP_BAT_OK;
            3'd3:    return MOUSE_ID;
            3'd4:    return CMD_ENABLE;
            3'd5:    return RSP_ACK;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 frame: clock inhibit, request-to-send, shift-out of d0..d7/parity/stop, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] data,
    input  logic       clk_s,
    input  logic       data_s,
    input  logic       clk_fall,
    output logic       busy,
    output logic       in_frame,
    output logic       done,
    output logic       nack,
    output logic       clk_oe,
    output logic       data_oe
);

    tx_state_t   state, state_n;
    logic [31:0] inh_cnt;
    logic [9:0]  shreg;
    logic [3:0]  bit_cnt;
    logic        drive_low;
    logic        ack_ok;

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= TX_IDLE;
            inh_cnt   <= '0;
            shreg     <= '1;
            bit_cnt   <= '0;
            drive_low <= 1'b0;
            ack_ok    <= 1'b0;
        end else begin
            state   <= state_n;
            inh_cnt <= (state == TX_INHIBIT) ? inh_cnt + 32'd1 : '0;
            if (start && state == TX_IDLE) begin
                shreg   <= {1'b1, ~^data, data};
                bit_cnt <= '0;
            end
            // Start bit is pulled low from RTS until the first device falling edge.
            if (state == TX_INHIBIT) begin
                drive_low <= 1'b1;
            end else if (state == TX_SHIFT && clk_fall) begin
                drive_low <= ~shreg[0];
                shreg     <= {1'b1, shreg[9:1]};
                bit_cnt   <= bit_cnt + 4'd1;
            end
            if (state == TX_ACK && clk_fall) ack_ok <= ~data_s;
        end
    end

    // NOTE: defaults come first so no path through the case can infer a latch.
    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            TX_IDLE:    if (start) state_n = TX_INHIBIT;
            TX_INHIBIT: if (inh_cnt == 32'(INHIBIT_CYC - 1)) state_n = TX_RTS;
            TX_RTS:     state_n = TX_SHIFT;
            TX_SHIFT:   if (clk_fall && bit_cnt == 4'd9) state_n = TX_ACK;
            TX_ACK:     if (clk_fall) state_n = TX_WAIT_HI;
            TX_WAIT_HI: if (clk_s) begin
                done    = 1'b1;
                state_n = TX_IDLE;
            end
            default:    state_n = TX_IDLE;
        endcase
        if (abort) begin
            state_n = TX_IDLE;
            done    = 1'b0;
        end
    end

    assign busy     = (state != TX_IDLE);
    assign in_frame = (state == TX_SHIFT) || (state == TX_ACK) || (state == TX_WAIT_HI);
    assign nack     = ~ack_ok;
    assign clk_oe   = (state == TX_INHIBIT) || (state == TX_RTS);
    assign data_oe  = (state == TX_RTS) || (state == TX_SHIFT && drive_low);

endmodule

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse init sequencer: Reset, BAT/ID check, Enable Data Reporting, with resend and retry handling.
module ps2_mouse_init
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC  = 9600,
    parameter int BIT_TIMEOUT  = 192000,
    parameter int RESP_TIMEOUT = 96000000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       restart,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] attempt
);

    init_state_t state, state_n;
    logic [2:0]  step, step_n;
    logic [1:0]  attempt_n;
    logic        resent, resent_n;

    logic [1:0]  clk_sync, data_sync;
    logic        clk_d, clk_s, data_s, clk_fall, clk_edge;

    logic        tx_start, tx_abort, tx_busy, tx_in_frame, tx_done, tx_nack;
    logic [7:0]  tx_data;

    logic        rx_in_frame, rx_done, frame_ok;
    logic [3:0]  rx_cnt;
    logic [9:0]  rx_shift, rx_shift_n;
    logic [7:0]  rx_byte;

    logic [31:0] idle_cnt;
    logic        timed_bit, timed_resp, timeout;

    // Synchronizers reset to the idle-high line level so reset creates no edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_d     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_d     <= clk_s;
        end
    end

    assign clk_s    = clk_sync[1];
    assign data_s   = data_sync[1];
    assign clk_fall = clk_d & ~clk_s;
    assign clk_edge = clk_d ^ clk_s;

    ps2_host_tx #(.INHIBIT_CYC(INHIBIT_CYC)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .start    (tx_start),
        .abort    (tx_abort),
        .data     (tx_data),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .clk_fall (clk_fall),
        .busy     (tx_busy),
        .in_frame (tx_in_frame),
        .done     (tx_done),
        .nack     (tx_nack),
        .clk_oe   (ps2_clk_oe),
        .data_oe  (ps2_data_oe)
    );

    assign rx_shift_n = {data_s, rx_shift[9:1]};
    assign rx_done    = (state == ST_RX) && rx_in_frame && clk_fall && (rx_cnt == 4'd9);
    assign rx_byte    = rx_shift[7:0];
    assign frame_ok   = rx_shift[9] && (rx_shift[8] == ~^rx_byte);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_in_frame <= 1'b0;
            rx_cnt      <= '0;
            rx_shift    <= '0;
        end else if (state != ST_RX) begin
            rx_in_frame <= 1'b0;
        end else if (clk_fall) begin
            if (!rx_in_frame) begin
                if (!data_s) begin
                    rx_in_frame <= 1'b1;
                    rx_cnt      <= '0;
                end
            end else begin
                rx_shift <= rx_shift_n;
                rx_cnt   <= rx_cnt + 4'd1;
                if (rx_cnt == 4'd9) rx_in_frame <= 1'b0;
            end
        end
    end

    // Idle counter runs only while a device clock edge is actually awaited.
    assign timed_bit  = (state == ST_TX && tx_in_frame) || (state == ST_RX && rx_in_frame);
    assign timed_resp = (state == ST_RX) && !rx_in_frame;
    assign timeout    = (timed_bit  && idle_cnt > 32'(BIT_TIMEOUT)) ||
                        (timed_resp && idle_cnt > 32'(RESP_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                     idle_cnt <= '0;
        else if (clk_edge || !(timed_bit || timed_resp)) idle_cnt <= '0;
        else                                           idle_cnt <= idle_cnt + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_START;
            step    <= '0;
            attempt <= '0;
            resent  <= 1'b0;
        end else begin
            state   <= state_n;
            step    <= step_n;
            attempt <= attempt_n;
            resent  <= resent_n;
        end
    end

    always_comb begin
        state_n   = state;
        step_n    = step;
        attempt_n = attempt;
        resent_n  = resent;
        tx_start  = 1'b0;
        tx_abort  = 1'b0;
        if (restart) begin
            state_n   = ST_START;
            attempt_n = '0;
            tx_abort  = 1'b1;
        end else begin
            case (state)
                ST_START: begin
                    step_n   = '0;
                    resent_n = 1'b0;
                    if (!tx_busy) begin
                        tx_start = 1'b1;
                        state_n  = ST_TX;
                    end
                end
                ST_NEXT: begin
                    if (step == 3'(NUM_STEPS)) begin
                        state_n = ST_DONE;
                    end else if (step_is_tx(step)) begin
                        if (!tx_busy) begin
                            tx_start = 1'b1;
                            state_n  = ST_TX;
                        end
                    end else begin
                        state_n = ST_RX;
                    end
                end
                ST_TX: begin
                    if (timeout) begin
                        tx_abort = 1'b1;
                        state_n  = ST_FAIL;
                    end else if (tx_done) begin
                        if (tx_nack) begin
                            state_n = ST_FAIL;
                        end else begin
                            step_n  = step + 3'd1;
                            state_n = ST_NEXT;
                        end
                    end
                end
                ST_RX: begin
                    if (timeout)      state_n = ST_FAIL;
                    else if (rx_done) state_n = ST_CHECK;
                end
                ST_CHECK: begin
                    if (frame_ok && rx_byte == step_byte(step)) begin
                        step_n   = step + 3'd1;
                        resent_n = 1'b0;
                        state_n  = ST_NEXT;
                    end else if (frame_ok && rx_byte == RSP_RESEND && step != 3'd0 &&
                                 step_is_tx(step - 3'd1) && !resent) begin
                        // One resend per command: step back to the TX step and re-inhibit.
                        resent_n = 1'b1;
                        step_n   = step - 3'd1;
                        state_n  = ST_NEXT;
                    end else begin
                        state_n = ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    if (int'(attempt) < MAX_RETRY - 1) begin
                        attempt_n = attempt + 2'd1;
                        state_n   = ST_START;
                    end else begin
                        state_n = ST_ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data    = step_byte(step_n);
    assign init_done  = (state == ST_DONE);
    assign init_error = (state == ST_ERROR);

endmodule
